// File: rtl/adc_thermometer_to_binary_if.sv
// Sample stream and error-counter control bundle for the thermometer-to-binary decoder.
// The decoder sits on the slave side; the sample source and register block sit on the master side.
interface adc_thermometer_to_binary_if #(
    parameter int BIN_WIDTH    = 8,
    parameter int THERM_WIDTH  = 2**BIN_WIDTH,
    parameter int ERRCNT_WIDTH = 16
);
    logic                    in_valid;
    logic [THERM_WIDTH-1:0]  in_thermometer;
    logic                    err_clear;
    logic                    out_valid;
    logic [BIN_WIDTH-1:0]    out_binary;
    logic                    out_code_err;
    logic [ERRCNT_WIDTH-1:0] err_count;

    modport master (
        output in_valid, in_thermometer, err_clear,
        input  out_valid, out_binary, out_code_err, err_count
    );

    modport slave (
        input  in_valid, in_thermometer, err_clear,
        output out_valid, out_binary, out_code_err, err_count
    );
endinterface

// File: rtl/adc_thermometer_to_binary.sv
// Two-stage thermometer-to-binary decoder with 3-tap bubble correction,
// per-sample code-error flag and a saturating error counter.
module adc_thermometer_to_binary #(
    parameter int BIN_WIDTH    = 8,
    parameter int THERM_WIDTH  = 2**BIN_WIDTH,
    parameter int ERRCNT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    adc_thermometer_to_binary_if.slave bus
);
    // The level can reach THERM_WIDTH, one more than the largest binary output.
    localparam int                LVL_W   = $clog2(THERM_WIDTH + 1);
    localparam logic [LVL_W-1:0]  MAX_LVL = LVL_W'((2**BIN_WIDTH) - 1);

    logic                    r_s1_valid;
    logic [THERM_WIDTH-1:0]  r_s1_therm;
    logic                    r_out_valid;
    logic [BIN_WIDTH-1:0]    r_out_binary;
    logic                    r_out_code_err;
    logic [ERRCNT_WIDTH-1:0] r_err_count;

    logic [THERM_WIDTH+1:0]  w_ext;
    logic [THERM_WIDTH-1:0]  w_corr;
    logic                    w_code_err;
    logic [LVL_W-1:0]        w_level;
    logic [LVL_W-1:0]        w_sat;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_therm <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_therm <= bus.in_thermometer;
            end
        end
    end

    // Boundary taps: below bit 0 reads as filled, above the top bit as empty.
    assign w_ext      = {1'b0, r_s1_therm, 1'b1};
    assign w_code_err = |(w_ext[THERM_WIDTH+1:1] & ~w_ext[THERM_WIDTH:0]);

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        w_corr  = '0;
        w_level = '0;
        for (int i = 0; i < THERM_WIDTH; i++) begin
            w_corr[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) | (w_ext[i+1] & w_ext[i+2]);
            w_level   = w_level + LVL_W'(w_corr[i]);
        end
    end

    assign w_sat = (w_level > MAX_LVL) ? MAX_LVL : w_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_binary   <= '0;
            r_out_code_err <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_binary   <= BIN_WIDTH'(w_sat);
                r_out_code_err <= w_code_err;
            end
            if (bus.err_clear) begin
                r_err_count <= '0;
            end else if (r_out_valid && r_out_code_err && !(&r_err_count)) begin
                r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_binary   = r_out_binary;
    assign bus.out_code_err = r_out_code_err;
    assign bus.err_count    = r_err_count;
endmodule

// File: tb/tb_adc_thermometer_to_binary.sv
// Scoreboard bench: 4-bit decoder (main + 2-bit error counter variant) and an 8-bit round-trip decoder.
module tb_adc_thermometer_to_binary;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // shared stimulus for the two 4-bit instances
    logic        in_v  = 1'b0;
    logic [15:0] in_t  = '0;
    logic        clr_c = 1'b0;
    logic         rt_v   = 1'b0;
    logic [255:0] rt_t   = '0;
    logic [7:0]   rt_val = '0;

    adc_thermometer_to_binary_if #(.BIN_WIDTH(4), .THERM_WIDTH(16),  .ERRCNT_WIDTH(16)) bus_a ();
    adc_thermometer_to_binary_if #(.BIN_WIDTH(4), .THERM_WIDTH(16),  .ERRCNT_WIDTH(2))  bus_c ();
    adc_thermometer_to_binary_if #(.BIN_WIDTH(8), .THERM_WIDTH(256), .ERRCNT_WIDTH(16)) bus_r ();

    assign bus_a.in_valid       = in_v;
    assign bus_a.in_thermometer = in_t;
    assign bus_a.err_clear      = 1'b0;
    assign bus_c.in_valid       = in_v;
    assign bus_c.in_thermometer = in_t;
    assign bus_c.err_clear      = clr_c;
    assign bus_r.in_valid       = rt_v;
    assign bus_r.in_thermometer = rt_t;
    assign bus_r.err_clear      = 1'b0;

    adc_thermometer_to_binary #(.BIN_WIDTH(4), .THERM_WIDTH(16),  .ERRCNT_WIDTH(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    adc_thermometer_to_binary #(.BIN_WIDTH(4), .THERM_WIDTH(16),  .ERRCNT_WIDTH(2))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));
    adc_thermometer_to_binary #(.BIN_WIDTH(8), .THERM_WIDTH(256), .ERRCNT_WIDTH(16)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));

    // Reference decoder: returns {code_err, level}
    function automatic logic [4:0] model4(input logic [15:0] r);
        logic [17:0] e;
        logic        legal;
        int          lvl;
        e     = {1'b0, r, 1'b1};
        legal = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (r == 16'((17'h1 << k) - 17'h1)) legal = 1'b1;
        end
        lvl = 0;
        for (int i = 0; i < 16; i++) begin
            if (int'(e[i]) + int'(e[i+1]) + int'(e[i+2]) >= 2) lvl++;
        end
        if (lvl > 15) lvl = 15;
        return {~legal, 4'(lvl)};
    endfunction

    // Scoreboard for dut_a: samples are pushed once the DUT has sampled them
    logic [4:0] q_a[$];
    logic [4:0] last_a = '0;
    logic [4:0] ea;
    logic [1:0] vp     = '0;
    int         cnt_a  = 0;
    logic        p_rst = 1'b1;
    logic        p_v   = 1'b0;
    logic [15:0] p_t   = '0;

    always @(negedge clk) begin
        if (p_rst) begin
            vp     = '0;
            q_a.delete();
            last_a = '0;
            cnt_a  = 0;
        end else begin
            vp = {vp[0], p_v};
            if (p_v) q_a.push_back(model4(p_t));
        end
        chk("a_valid", 32'(bus_a.out_valid), 32'(vp[1]));
        if (bus_a.out_valid) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected", 32'(bus_a.out_valid), 32'd0);
            end else begin
                ea = q_a.pop_front();
                chk("a_bin", 32'(bus_a.out_binary), 32'(ea[3:0]));
                chk("a_err", 32'(bus_a.out_code_err), 32'(ea[4]));
                last_a = ea;
                if (ea[4]) cnt_a++;
            end
        end else begin
            chk("a_hold_bin", 32'(bus_a.out_binary), 32'(last_a[3:0]));
            chk("a_hold_err", 32'(bus_a.out_code_err), 32'(last_a[4]));
        end
        p_rst = rst;
        p_v   = in_v;
        p_t   = in_t;
    end

    // Round-trip scoreboard for dut_r: expected output is the encoded value itself
    logic [7:0] q_r[$];
    logic [7:0] er;
    int         rt_seen = 0;
    logic       p_rst_r = 1'b1;
    logic       p_rv    = 1'b0;
    logic [7:0] p_rval  = '0;

    always @(negedge clk) begin
        if (p_rst_r) q_r.delete();
        else if (p_rv) q_r.push_back(p_rval);
        if (bus_r.out_valid) begin
            if (q_r.size() == 0) begin
                chk("r_unexpected", 32'(bus_r.out_valid), 32'd0);
            end else begin
                er = q_r.pop_front();
                chk("r_bin", 32'(bus_r.out_binary), 32'(er));
                chk("r_err", 32'(bus_r.out_code_err), 32'd0);
                rt_seen++;
            end
        end
        p_rst_r = rst;
        p_rv    = rt_v;
        p_rval  = rt_val;
    end

    task automatic drive(input logic v, input logic [15:0] t);
        in_v = v;
        in_t = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_v = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_rt(input int v);
        rt_v   = 1'b1;
        rt_val = 8'(v);
        rt_t   = '0;
        for (int i = 0; i < v; i++) rt_t[i] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset held two cycles while in_valid toggles
        drive(1'b1, 16'h00FF);
        chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_bin",   32'(bus_a.out_binary), 32'd0);
        chk("rst_cnt",   32'(bus_a.err_count), 32'd0);
        drive(1'b0, 16'h0000);
        chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_bin",   32'(bus_a.out_binary), 32'd0);
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        chk("rel_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rel_bin",   32'(bus_a.out_binary), 32'd0);
        chk("rel_cnt",   32'(bus_a.err_count), 32'd0);

        // legal sweep, then full-scale saturation
        for (int k = 0; k < 16; k++) drive(1'b1, 16'((17'h1 << k) - 17'h1));
        drive(1'b1, 16'hFFFF);
        idle(3);
        chk("sweep_cnt", 32'(bus_a.err_count), 32'd0);

        // single bubble flags one error
        drive(1'b1, 16'b0000_0000_0101_1111);
        idle(3);
        chk("bubble_cnt", 32'(bus_a.err_count), 32'd1);

        repeat (12) drive(1'b1, 16'($urandom));
        idle(3);
        chk("rand_cnt", 32'(bus_a.err_count), 32'(cnt_a));

        // valid gaps
        drive(1'b1, 16'h0003);
        drive(1'b0, 16'h0000);
        drive(1'b1, 16'h0007);
        drive(1'b1, 16'h000F);
        idle(3);

        // reset while two error samples are in flight
        drive(1'b1, 16'h0002);
        rst = 1'b1;
        drive(1'b1, 16'h0004);
        rst = 1'b0;
        idle(3);
        chk("mid_cnt_a", 32'(bus_a.err_count), 32'd0);
        chk("mid_cnt_c", 32'(bus_c.err_count), 32'd0);

        // 2-bit counter saturation
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0002);
            idle(3);
            chk("sat_cnt_c", 32'(bus_c.err_count), 32'((i + 1 > 3) ? 3 : i + 1));
        end
        // clear overlapping an error sample wins
        drive(1'b1, 16'h0002);
        clr_c = 1'b1;
        idle(2);
        clr_c = 1'b0;
        idle(2);
        chk("clr_cnt_c", 32'(bus_c.err_count), 32'd0);
        chk("cnt_a_after", 32'(bus_a.err_count), 32'(cnt_a));

        // encode/decode round trip at 8 bits
        for (int v = 0; v < 256; v++) drive_rt(v);
        rt_v = 1'b0;
        idle(4);
        chk("rt_seen", 32'(rt_seen), 32'd256);
        chk("rt_cnt",  32'(bus_r.err_count), 32'd0);
        chk("rt_left", 32'(q_r.size()), 32'd0);
        chk("a_left",  32'(q_a.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
